// File: rtl/apb_regbus_bridge_pkg.sv
// Shared types and helpers for the APB-to-register-bus bridge.
// Holds the FSM encoding, the default bus widths and the transfer error check.
package regbus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A transfer errors if it is not word aligned or falls outside the register window.
  // The caller zero-extends paddr, so any bit at or above addr_w marks it out of range.
  function automatic logic addr_err(input logic [31:0] paddr, input int unsigned addr_w);
    return (paddr[1:0] != 2'b00) || ((paddr >> addr_w) != 32'd0);
  endfunction

endpackage

// File: rtl/apb_regbus_bridge.sv
// APB3 completer that turns each APB transfer into a single strobe on the register bus.
// One transfer in flight; all outputs registered; reads give up after TIMEOUT cycles.
module apb_regbus_bridge
  import regbus_pkg::*;
#(
  parameter int unsigned PADDR_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]  pwdata,
  output logic [DATA_WIDTH-1:0]  prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   chip_select,
  output logic                   write_en,
  output logic                   read_en,
  output logic [DATA_WIDTH-1:0]  write_data,
  input  logic [DATA_WIDTH-1:0]  read_data,
  input  logic                   data_valid
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;
  logic                    setup, setup_err;

  assign setup     = psel && !penable;
  assign setup_err = addr_err(32'(paddr), ADDR_WIDTH);
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Strobe/response outputs default low; each state re-asserts what it owns next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = paddr[ADDR_WIDTH-1:0];
          wdata_d = pwdata;
          if (setup_err) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (pwrite) begin
            state_d = WRITE;
            cs_d    = 1'b1;
            we_d    = 1'b1;
          end else begin
            state_d = READ;
            cs_d    = 1'b1;
            re_d    = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      WRITE: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d  = DONE;
          pready_d = 1'b1;
        end
      end
      READ: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (data_valid) begin
          state_d  = DONE;
          prdata_d = read_data;
          pready_d = 1'b1;
        end else if (cnt_inc >= TO_CNT) begin
          state_d   = DONE;
          cnt_d     = cnt_inc;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          cs_d  = 1'b1;
          re_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!psel) cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign addr        = addr_q;
  assign chip_select = cs_q;
  assign write_en    = we_q;
  assign read_en     = re_q;
  assign write_data  = wdata_q;

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// Bench for apb_regbus_bridge: a register-file responder with programmable latency,
// fixed vectors, hand-built reset/abort sequences and random transfers against a transfer-level model.
module tb_apb_regbus_bridge;

  localparam int PAW = 12;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TO  = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [PAW-1:0] paddr = '0;
  logic [DW-1:0]  pwdata = '0;
  logic [DW-1:0]  prdata, write_data, read_data;
  logic           pready, pslverr, chip_select, write_en, read_en, data_valid;
  logic [AW-1:0]  addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_regbus_bridge #(.PADDR_WIDTH(PAW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .addr(addr), .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
    .write_data(write_data), .read_data(read_data), .data_valid(data_valid)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 7) ? 32'h0001_0000 : (32'hA500_0000 | 32'(i));
  endfunction

  // Register-file responder: data_valid arrives rf_lat cycles after read_en rises.
  logic [DW-1:0] rf_mem [64];
  int            rf_cnt;
  int            rf_lat = 1;
  bit            rf_respond = 1'b1;

  assign read_data = rf_mem[addr[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) rf_mem[i] <= init_val(i);
      rf_cnt     <= 0;
      data_valid <= 1'b0;
    end else begin
      if (chip_select && write_en) rf_mem[addr[7:2]] <= write_data;
      rf_cnt     <= read_en ? rf_cnt + 1 : 0;
      data_valid <= read_en && rf_respond && (rf_cnt + 1 == rf_lat);
    end
  end

  // Transfer-level reference: register contents and the last good read value.
  logic [31:0] ref_mem [64];
  logic [31:0] prdata_m;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    prdata_m = '0;
  endtask

  task automatic model(input logic [11:0] a, input logic wr, input logic [31:0] wd,
                       input int lat, input bit resp,
                       output int cyc, output logic err, output int stb, output logic [31:0] prd);
    err = (a[1:0] != 2'b00) || (a >= 12'd256);
    if (err) begin
      cyc = 1; stb = 0;
    end else if (wr) begin
      cyc = 2; stb = 1; ref_mem[a[7:2]] = wd;
    end else if (resp && lat < TO) begin
      cyc = lat + 2; stb = lat + 1; prdata_m = ref_mem[a[7:2]];
    end else begin
      cyc = TO + 1; stb = TO; err = 1'b1;
    end
    prd = prdata_m;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer starting at the next edge; cyc is the T index of pready (-1 if none).
  task automatic xfer(input logic [11:0] a, input logic wr, input logic [31:0] wd,
                      output int cyc, output logic err, output int stb, output int cs_n,
                      output bit proto_ok);
    proto_ok = 1'b1; cyc = -1; stb = 0; cs_n = 0; err = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(negedge clk);
    if (pready || chip_select || pslverr) proto_ok = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      if (chip_select) cs_n++;
      if (write_en || read_en) stb++;
      if ((write_en && read_en) || ((write_en || read_en) && !chip_select) || (pslverr && !pready))
        proto_ok = 1'b0;
      if (pready) begin
        cyc = t; err = pslverr;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int k = 1; k < n; k++) @(posedge clk);
  endtask

  task automatic run_one(input string tag, input logic [11:0] a, input logic wr, input logic [31:0] wd,
                         input int lat, input bit resp,
                         input int e_cyc, input logic e_err, input int e_stb, input logic [31:0] e_prd);
    int cyc, stb, cs_n;
    logic err;
    bit ok;
    rf_lat = lat; rf_respond = resp;
    xfer(a, wr, wd, cyc, err, stb, cs_n, ok);
    chk({tag, "_latency"}, 128'(cyc), 128'(e_cyc));
    chk({tag, "_pslverr"}, 128'(err), 128'(e_err));
    chk({tag, "_strobes"}, 128'(stb), 128'(e_stb));
    chk({tag, "_cs"}, 128'(cs_n), 128'(e_stb));
    chk({tag, "_prdata"}, 128'(prdata), 128'(e_prd));
    chk({tag, "_protocol"}, 128'(ok), 128'(1));
  endtask

  typedef struct {
    logic [11:0] a;
    logic        wr;
    logic [31:0] wd;
    int          lat;
    bit          resp;
    int          cyc;
    logic        err;
    int          stb;
    logic [31:0] prd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   m_cyc, m_stb, lat, flag;
    logic m_err, wr;
    logic [31:0] m_prd, wd;
    logic [11:0] a;
    bit   resp;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {prdata, pready, pslverr, addr, chip_select, write_en, read_en, write_data}, '0);
    rst = 1'b0;

    //           addr   wr  wdata          lat resp cyc err stb prdata
    vecs.push_back('{12'h008, 1, 32'hDEADBEEF, 1, 1, 2,  0, 1,  32'h0});
    vecs.push_back('{12'h01C, 0, 32'h0,        1, 1, 3,  0, 2,  32'h0001_0000});
    vecs.push_back('{12'h006, 0, 32'h0,        1, 1, 1,  1, 0,  32'h0001_0000});
    vecs.push_back('{12'h104, 0, 32'h0,        1, 1, 1,  1, 0,  32'h0001_0000});
    vecs.push_back('{12'h104, 1, 32'h11111111, 1, 1, 1,  1, 0,  32'h0001_0000});
    vecs.push_back('{12'h00C, 0, 32'h0,        1, 0, 16, 1, 15, 32'h0001_0000});
    vecs.push_back('{12'h004, 1, 32'hCAFEF00D, 1, 1, 2,  0, 1,  32'h0001_0000});
    vecs.push_back('{12'h004, 0, 32'h0,        1, 1, 3,  0, 2,  32'hCAFEF00D});
    vecs.push_back('{12'h008, 0, 32'h0,        3, 1, 5,  0, 4,  32'hDEADBEEF});
    vecs.push_back('{12'h0FC, 1, 32'h12345678, 1, 1, 2,  0, 1,  32'hDEADBEEF});
    vecs.push_back('{12'h0FC, 0, 32'h0,        1, 1, 3,  0, 2,  32'h12345678});
    vecs.push_back('{12'h100, 0, 32'h0,        1, 1, 1,  1, 0,  32'h12345678});
    vecs.push_back('{12'h002, 1, 32'h55555555, 1, 1, 1,  1, 0,  32'h12345678});
    vecs.push_back('{12'h008, 0, 32'h0,        14, 1, 16, 0, 15, 32'hDEADBEEF});
    vecs.push_back('{12'h01C, 0, 32'h0,        15, 1, 16, 1, 15, 32'hDEADBEEF});

    // Applied back-to-back: each setup phase directly follows the previous pready.
    for (int i = 0; i < vecs.size(); i++) begin
      model(vecs[i].a, vecs[i].wr, vecs[i].wd, vecs[i].lat, vecs[i].resp, m_cyc, m_err, m_stb, m_prd);
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].wr, vecs[i].wd, vecs[i].lat, vecs[i].resp,
              vecs[i].cyc, vecs[i].err, vecs[i].stb, vecs[i].prd);
    end
    idle(2);

    // psel dropped mid-READ: strobe falls next cycle and no response follows.
    rf_respond = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_read_active", 128'(read_en), 128'(1));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    flag = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0 && (read_en || chip_select || pready || pslverr)) flag++;
    end
    chk("abort_quiet", 128'(flag), 128'(0));
    model(12'h008, 1'b0, '0, 2, 1'b1, m_cyc, m_err, m_stb, m_prd);
    run_one("after_abort", 12'h008, 1'b0, '0, 2, 1'b1, m_cyc, m_err, m_stb, m_prd);
    idle(1);

    // Asynchronous reset mid-READ, away from any clock edge.
    rf_respond = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h01C; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_mid_read_active", 128'(read_en), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        {prdata, pready, pslverr, addr, chip_select, write_en, read_en, write_data}, '0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    model(12'h010, 1'b1, 32'h0BADF00D, 1, 1'b1, m_cyc, m_err, m_stb, m_prd);
    run_one("post_rst_wr", 12'h010, 1'b1, 32'h0BADF00D, 1, 1'b1, m_cyc, m_err, m_stb, m_prd);
    model(12'h010, 1'b0, '0, 1, 1'b1, m_cyc, m_err, m_stb, m_prd);
    run_one("post_rst_rd", 12'h010, 1'b0, '0, 1, 1'b1, m_cyc, m_err, m_stb, m_prd);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      a = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r < 8) a = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else            a = 12'($urandom_range(256, 4095));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      lat  = $urandom_range(1, 4);
      resp = ($urandom_range(0, 7) != 0);
      model(a, wr, wd, lat, resp, m_cyc, m_err, m_stb, m_prd);
      run_one($sformatf("rnd%0d", i), a, wr, wd, lat, resp, m_cyc, m_err, m_stb, m_prd);
      r = $urandom_range(0, 2);
      if (r != 0) idle(r);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
